// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: immediate, format code, illegal flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic signed [31:0] imm32;

    // Every format fits in 32 bits; the final widening sign-extends from bit 31,
    // which is always zero for the zimm case.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {inst[31:12], 12'b0};
                fmt   = FMT_U;
            end
            OPC_JAL: begin
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                fmt   = FMT_J;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32: begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
                fmt   = FMT_I;
            end
            OPC_STORE: begin
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                fmt   = FMT_B;
            end
            OPC_SYSTEM: begin
                if (inst[14]) begin
                    imm32 = {27'b0, inst[19:15]};
                    fmt   = FMT_Z;
                end else begin
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                    fmt   = FMT_I;
                end
            end
            OPC_OP, OPC_OP32, OPC_MISCMEM: begin
                imm32 = '0;
                fmt   = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage with valid/ready flow control and a
// one-entry skid register behind the output register.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;
    logic             dec_illegal;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    logic             accept;
    logic             stalled;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // in_ready comes straight from a flop so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign stalled  = out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_fmt      <= FMT_NONE;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (stalled) begin
            if (accept) begin
                skid_valid   <= 1'b1;
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_illegal <= dec_illegal;
                skid_tag     <= in_tag;
            end
        end else if (skid_valid) begin
            // Skid drains ahead of any new input; in_ready is low so nothing is accepted.
            out_valid   <= 1'b1;
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_illegal <= skid_illegal;
            out_tag     <= skid_tag;
            skid_valid  <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_illegal <= dec_illegal;
            out_tag     <= in_tag;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors at XLEN 32 and 64, back-pressure, flush, reset.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_tag;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_tag32;
    logic [2:0]  out_fmt32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [2:0]  out_fmt64;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_inst(input logic [11:0] imm);
        return {imm, 20'h00093};
    endfunction

    task automatic chk_reset_state(input string name);
        chk({name, " valid"},   {63'b0, out_valid32},   64'd0);
        chk({name, " ready"},   {63'b0, in_ready32},    64'd1);
        chk({name, " imm"},     {32'b0, out_imm32},     64'd0);
        chk({name, " fmt"},     {61'b0, out_fmt32},     64'd0);
        chk({name, " illegal"}, {63'b0, out_illegal32}, 64'd0);
        chk({name, " tag"},     {32'b0, out_tag32},     64'd0);
        chk({name, " imm64"},   out_imm64,              64'd0);
        chk({name, " valid64"}, {63'b0, out_valid64},   64'd0);
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        illegal;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // addi -1
        vecs[1]  = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0}; // lui
        vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0}; // beq -4
        vecs[3]  = '{32'h0080006F, 32'h00000008, 64'h0000000000000008, 3'd5, 1'b0}; // jal 8
        vecs[4]  = '{32'h3401D073, 32'h00000003, 64'h0000000000000003, 3'd6, 1'b0}; // csrrwi
        vecs[5]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1}; // bad opcode
        vecs[6]  = '{32'hFE002C23, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0}; // sw -8
        vecs[7]  = '{32'h003100B3, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0}; // add
        vecs[8]  = '{32'h80000037, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // lui neg
        vecs[9]  = '{32'h34011073, 32'h00000340, 64'h0000000000000340, 3'd1, 1'b0}; // csrrw
        vecs[10] = '{32'h00000000, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1}; // inst[1:0]=00

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_tag = '0;
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Back-to-back decode stream; each result lands one cycle after its accept.
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_tag = 32'(i + 100);
            tick();
            chk($sformatf("dec%0d valid", i),   {63'b0, out_valid32},   64'd1);
            chk($sformatf("dec%0d imm32", i),   {32'b0, out_imm32},     {32'b0, vecs[i].imm32});
            chk($sformatf("dec%0d imm64", i),   out_imm64,              vecs[i].imm64);
            chk($sformatf("dec%0d fmt", i),     {61'b0, out_fmt32},     {61'b0, vecs[i].fmt});
            chk($sformatf("dec%0d fmt64", i),   {61'b0, out_fmt64},     {61'b0, vecs[i].fmt});
            chk($sformatf("dec%0d illegal", i), {63'b0, out_illegal32}, {63'b0, vecs[i].illegal});
            chk($sformatf("dec%0d tag", i),     {32'b0, out_tag32},     64'(i + 100));
        end
        in_valid = 1'b0;
        tick();
        chk("drain valid", {63'b0, out_valid32}, 64'd0);
        chk("drain hold imm", {32'b0, out_imm32}, 64'd0);

        // Back-pressure: tags 1,2 accepted, tag 3 held until the skid drains.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = addi_inst(12'd1); in_tag = 32'd1;
        chk("bp ready t1", {63'b0, in_ready32}, 64'd1);
        tick();
        chk("bp valid t1", {63'b0, out_valid32}, 64'd1);
        chk("bp tag t1",   {32'b0, out_tag32},   64'd1);
        in_inst = addi_inst(12'd2); in_tag = 32'd2;
        chk("bp ready t2", {63'b0, in_ready32}, 64'd1);
        tick();
        chk("bp ready after t2", {63'b0, in_ready32}, 64'd0);
        chk("bp ready64 after t2", {63'b0, in_ready64}, 64'd0);
        chk("bp hold tag", {32'b0, out_tag32}, 64'd1);
        in_inst = addi_inst(12'd3); in_tag = 32'd3;
        tick();
        chk("bp still blocked", {63'b0, in_ready32}, 64'd0);
        chk("bp still t1", {32'b0, out_tag32}, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp out t2 valid", {63'b0, out_valid32}, 64'd1);
        chk("bp out t2 tag",   {32'b0, out_tag32},   64'd2);
        chk("bp out t2 imm",   {32'b0, out_imm32},   64'd2);
        chk("bp ready reopen", {63'b0, in_ready32},  64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp out t3 valid", {63'b0, out_valid32}, 64'd1);
        chk("bp out t3 tag",   {32'b0, out_tag32},   64'd3);
        chk("bp out t3 imm",   {32'b0, out_imm32},   64'd3);
        tick();
        chk("bp no dup", {63'b0, out_valid32}, 64'd0);

        // Flush with both entries full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = addi_inst(12'd4); in_tag = 32'd4;
        tick();
        in_inst = addi_inst(12'd5); in_tag = 32'd5;
        tick();
        chk("fl full", {63'b0, in_ready32}, 64'd0);
        flush = 1'b1; in_inst = addi_inst(12'd9); in_tag = 32'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl valid", {63'b0, out_valid32}, 64'd0);
        chk("fl ready", {63'b0, in_ready32},  64'd1);
        tick();
        chk("fl no t9", {63'b0, out_valid32}, 64'd0);

        // Flush coinciding with a real accept into an empty stage.
        flush = 1'b1; in_valid = 1'b1; in_tag = 32'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl accept dropped", {63'b0, out_valid32}, 64'd0);
        chk("fl accept dropped64", {63'b0, out_valid64}, 64'd0);

        // Reset mid-stream with output and skid occupied.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = addi_inst(12'd6); in_tag = 32'd6;
        tick();
        in_inst = addi_inst(12'd7); in_tag = 32'd7;
        tick();
        chk("rs full", {63'b0, in_ready32}, 64'd0);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk_reset_state("midrst");
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'd8; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post rst valid", {63'b0, out_valid32}, 64'd1);
        chk("post rst tag",   {32'b0, out_tag32},   64'd8);
        chk("post rst imm",   {32'b0, out_imm32},   64'hFFFFFFFF);
        tick();
        chk("post rst drained", {63'b0, out_valid32}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
